// File: rtl/fpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpu_mem_pkg
// Description : Shared types and default widths for the FPU memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_mem_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LEN_W   = 10;

    // Requester slots on the arbiter
    localparam int REQ_CONF = 0;
    localparam int REQ_RD   = 1;
    localparam int REQ_WR   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/fpu_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fpu_rr_pick
// Description : Combinational round-robin picker; first request at or after
//               the pointer, searching upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_any
);

    logic [PTR_W:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!o_any && i_req[w_idx[PTR_W-1:0]]) begin
                o_winner[w_idx[PTR_W-1:0]] = 1'b1;
                o_any                      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mem_arbiter
// Description : Round-robin burst arbiter sharing one memory port among the
//               FPU config loader, read engine and write engine.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_mem_arbiter
    import fpu_mem_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        beat_valid,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        burst_done,
    output logic                      err_stray,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LEN_W-1:0]          mem_len,
    output logic                      mem_wvalid,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_wready,
    input  logic                      mem_rvalid,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int               PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic [NUM_REQ-1:0]   w_win;
    logic                 w_any;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     w_win_idx;
    logic                 r_write;
    logic [ADDR_W-1:0]    r_addr;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic [LEN_W-1:0]     w_win_len;
    logic                 r_err_stray;
    logic                 w_rd_data;
    logic                 w_wr_data;
    logic                 w_beat;

    fpu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    assign w_win_len = req_len[w_win_idx*LEN_W +: LEN_W];
    assign w_rd_data = (r_state == DATA) && !r_write;
    assign w_wr_data = (r_state == DATA) && r_write;
    assign w_beat    = (w_rd_data && mem_rvalid) || (w_wr_data && mem_wready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = (w_win_len == '0) ? DONE : CMD;
                end
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_beat && (r_cnt == LEN_W'(1))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_req_ready <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_err_stray <= 1'b0;
        end else begin
            r_req_ready <= '0;
            // Only a read burst in its data phase may consume mem_rvalid
            r_err_stray <= mem_rvalid && !w_rd_data;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_win;
                        r_req_ready <= w_win;
                        r_owner     <= w_win_idx;
                        r_write     <= req_write[w_win_idx];
                        r_addr      <= req_addr[w_win_idx*ADDR_W +: ADDR_W];
                        r_len       <= w_win_len;
                    end
                end
                CMD: begin
                    if (mem_cmd_ready) begin
                        r_cnt <= r_len;
                    end
                end
                DATA: begin
                    if (w_beat && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                DONE: begin
                    r_grant <= '0;
                    r_ptr   <= (r_owner == C_LAST) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign grant         = r_grant;
    assign beat_valid    = w_beat ? r_grant : '0;
    assign rdata         = mem_rdata;
    assign burst_done    = (r_state == DONE) ? r_grant : '0;
    assign err_stray     = r_err_stray;
    assign mem_cmd_valid = (r_state == CMD);
    assign mem_write     = r_write;
    assign mem_addr      = r_addr;
    assign mem_len       = r_len;
    assign mem_wvalid    = w_wr_data;
    assign mem_wdata     = req_wdata[r_owner*DATA_W +: DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_fpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_mem_arbiter
// Description : Self-checking bench for fpu_mem_arbiter: vector table, directed
//               burst sequences and random traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 10;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid, req_write, req_ready, grant, beat_valid, burst_done;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            err_stray, mem_cmd_valid, mem_cmd_ready, mem_write;
    logic            mem_wvalid, mem_wready, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [LW-1:0]   mem_len;

    int n_vec = 0;
    int n_err = 0;

    fpu_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .grant         (grant),
        .beat_valid    (beat_valid),
        .rdata         (rdata),
        .burst_done    (burst_done),
        .err_stray     (err_stray),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_len       (mem_len),
        .mem_wvalid    (mem_wvalid),
        .mem_wdata     (mem_wdata),
        .mem_wready    (mem_wready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_grant;
    } vec_t;

    vec_t        tbl [10];
    logic [2:0]  exp_ord [6];
    logic [2:0]  got_q [$];
    logic [4:0]  pat;
    int          sent, seen;

    // Transaction-level reference model state
    int          m_busy, m_owner, m_len, m_write, m_cmd_acc, m_left;
    int          m_done, m_new, m_stray, m_ptr;
    logic [31:0] m_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] oh(input int i);
        return 3'b001 << i;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_len = 0; m_write = 0; m_cmd_acc = 0;
        m_left = 0; m_done = 0; m_new = 0; m_stray = 0; m_ptr = 0; m_addr = '0;
    endtask

    // Check this cycle's outputs against the model, then advance it over the edge
    task automatic model_cycle();
        logic [2:0] own;
        bit         dphase;
        bit         beat;
        bit         found;
        #1;
        own    = m_busy != 0 ? oh(m_owner) : 3'b000;
        dphase = (m_busy != 0) && (m_cmd_acc != 0) && (m_left > 0);
        beat   = dphase && ((m_write != 0) ? mem_wready : mem_rvalid);
        chk("rnd_grant", grant, own);
        chk("rnd_req_ready", req_ready, m_new != 0 ? own : 3'b000);
        chk("rnd_burst_done", burst_done, m_done != 0 ? own : 3'b000);
        chk("rnd_cmd_valid", mem_cmd_valid, (m_busy != 0) && (m_cmd_acc == 0) && (m_done == 0));
        if ((m_busy != 0) && (m_cmd_acc == 0) && (m_done == 0)) begin
            chk("rnd_cmd_addr", mem_addr, m_addr);
            chk("rnd_cmd_len", mem_len, m_len);
            chk("rnd_cmd_write", mem_write, m_write);
        end
        chk("rnd_wvalid", mem_wvalid, dphase && (m_write != 0));
        chk("rnd_beat_valid", beat_valid, beat ? own : 3'b000);
        if (dphase && (m_write != 0)) chk("rnd_wdata", mem_wdata, req_wdata[m_owner*32 +: 32]);
        chk("rnd_rdata", rdata, mem_rdata);
        chk("rnd_err_stray", err_stray, m_stray);
        if (rst) begin
            model_reset();
        end else begin
            m_stray = (mem_rvalid && !(dphase && (m_write == 0))) ? 1 : 0;
            m_new   = 0;
            if (m_done != 0) begin
                m_busy = 0;
                m_done = 0;
                m_ptr  = (m_owner + 1) % 3;
            end else if (m_busy != 0) begin
                if ((m_cmd_acc == 0) && mem_cmd_ready) begin
                    m_cmd_acc = 1;
                    m_left    = m_len;
                end else if (beat) begin
                    m_left--;
                    if (m_left == 0) m_done = 1;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    int j;
                    j = (m_ptr + k) % 3;
                    if (!found && req_valid[j]) begin
                        found     = 1'b1;
                        m_busy    = 1;
                        m_new     = 1;
                        m_owner   = j;
                        m_write   = req_write[j] ? 1 : 0;
                        m_addr    = req_addr[j*32 +: 32];
                        m_len     = int'(req_len[j*10 +: 10]);
                        m_cmd_acc = 0;
                        m_left    = 0;
                        m_done    = (m_len == 0) ? 1 : 0;
                    end
                end
            end
        end
    endtask

    initial begin
        // Zero-length bursts walk the round-robin pointer from reset value 0
        tbl[0] = '{3'b111, 3'b001};
        tbl[1] = '{3'b001, 3'b001};
        tbl[2] = '{3'b101, 3'b100};
        tbl[3] = '{3'b110, 3'b010};
        tbl[4] = '{3'b011, 3'b001};
        tbl[5] = '{3'b000, 3'b000};
        tbl[6] = '{3'b111, 3'b010};
        tbl[7] = '{3'b111, 3'b100};
        tbl[8] = '{3'b100, 3'b100};
        tbl[9] = '{3'b010, 3'b010};
        exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100;
        exp_ord[3] = 3'b001; exp_ord[4] = 3'b010; exp_ord[5] = 3'b100;

        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        mem_cmd_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cyc();
        cyc();
        chk("rst_grant", grant, 3'b000);
        chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_burst_done", burst_done, 3'b000);
        chk("rst_err_stray", err_stray, 0);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_len", mem_len, 0);
        chk("rst_wvalid", mem_wvalid, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].valid;
            cyc();
            chk("tbl_grant", grant, tbl[i].exp_grant);
            chk("tbl_req_ready", req_ready, tbl[i].exp_grant);
            chk("tbl_burst_done", burst_done, tbl[i].exp_grant);
            chk("tbl_cmd_valid", mem_cmd_valid, 0);
            req_valid = '0;
            cyc();
            chk("tbl_grant_clear", grant, 3'b000);
            chk("tbl_done_clear", burst_done, 3'b000);
        end

        // Single 4-beat read from the read engine
        req_valid = 3'b010; req_write[1] = 1'b0;
        req_addr[32 +: 32] = 32'h1000_0400; req_len[10 +: 10] = 10'd4;
        cyc();
        chk("rd_req_ready", req_ready, 3'b010);
        chk("rd_grant", grant, 3'b010);
        chk("rd_cmd_valid", mem_cmd_valid, 1);
        chk("rd_cmd_addr", mem_addr, 32'h1000_0400);
        chk("rd_cmd_len", mem_len, 4);
        chk("rd_cmd_write", mem_write, 0);
        req_valid = '0; req_addr[32 +: 32] = 32'hDEAD_BEEF;
        cyc();
        chk("rd_req_ready_once", req_ready, 3'b000);
        chk("rd_cmd_hold", mem_cmd_valid, 1);
        chk("rd_cmd_addr_hold", mem_addr, 32'h1000_0400);
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0;
        chk("rd_cmd_drop", mem_cmd_valid, 0);
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA + k;
            #1;
            chk("rd_beat_valid", beat_valid, 3'b010);
            chk("rd_rdata", rdata, 32'hA + k);
            cyc();
        end
        mem_rvalid = 1'b0;
        chk("rd_burst_done", burst_done, 3'b010);
        cyc();
        chk("rd_done_pulse", burst_done, 3'b000);
        chk("rd_grant_clear", grant, 3'b000);

        // Write burst under wready backpressure; requester drops valid mid-burst
        req_valid = 3'b100; req_write[2] = 1'b1; req_len[20 +: 10] = 10'd3;
        req_wdata[64 +: 32] = 32'h5000_0000;
        cyc();
        chk("wr_grant", grant, 3'b100);
        chk("wr_cmd_write", mem_write, 1);
        chk("wr_cmd_len", mem_len, 3);
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0; req_valid = '0;
        pat = 5'b10101; sent = 0; seen = 0;
        for (int k = 0; k < 5; k++) begin
            mem_wready = pat[k];
            #1;
            chk("wr_wvalid", mem_wvalid, 1);
            chk("wr_beat_valid", beat_valid, pat[k] ? 3'b100 : 3'b000);
            chk("wr_wdata", mem_wdata, 32'h5000_0000 + sent);
            if (beat_valid[2]) seen++;
            cyc();
            if (pat[k]) begin
                sent++;
                req_wdata[64 +: 32] = 32'h5000_0000 + sent;
            end
        end
        mem_wready = 1'b0;
        chk("wr_beat_count", seen, 3);
        chk("wr_burst_done", burst_done, 3'b100);
        chk("wr_wvalid_drop", mem_wvalid, 0);
        cyc();
        chk("wr_grant_clear", grant, 3'b000);

        // Stray read beat while idle
        mem_rvalid = 1'b1;
        #1;
        chk("stray_no_beat", beat_valid, 3'b000);
        cyc();
        mem_rvalid = 1'b0;
        chk("stray_pulse", err_stray, 1);
        cyc();
        chk("stray_pulse_end", err_stray, 0);

        // Zero-length burst from slot 0 moves the pointer to 1
        req_valid = 3'b001; req_len[0 +: 10] = 10'd0;
        cyc();
        chk("zl_req_ready", req_ready, 3'b001);
        chk("zl_burst_done", burst_done, 3'b001);
        chk("zl_no_cmd", mem_cmd_valid, 0);
        req_valid = '0;
        cyc();
        chk("zl_cmd_stays_low", mem_cmd_valid, 0);

        // Reset in the middle of an 8-beat read restores pointer 0
        req_valid = 3'b010; req_write[1] = 1'b0; req_len[10 +: 10] = 10'd8;
        cyc();
        chk("rst8_grant", grant, 3'b010);
        mem_cmd_ready = 1'b1; req_valid = '0;
        cyc();
        mem_cmd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            #1;
            chk("rst8_beat", beat_valid, 3'b010);
            cyc();
        end
        mem_rvalid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst8_grant_clear", grant, 3'b000);
        chk("rst8_cmd_clear", mem_cmd_valid, 0);
        req_valid = 3'b011;
        cyc();
        chk("rst8_ptr0_winner", req_ready, 3'b001);
        req_valid = '0;
        cyc();

        // Contention from reset: all three hold valid with 1-beat reads
        rst = 1'b1; req_valid = 3'b111; req_write = 3'b000;
        req_len = {10'd1, 10'd1, 10'd1};
        mem_cmd_ready = 1'b1; mem_rvalid = 1'b1;
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 100 && got_q.size() < 6; c++) begin
            if (req_ready != 3'b000) got_q.push_back(req_ready);
            if (got_q.size() < 6) cyc();
        end
        chk("rr_burst_count", got_q.size(), 6);
        for (int i = 0; i < got_q.size(); i++) chk("rr_order", got_q[i], exp_ord[i]);
        for (int i = 1; i < got_q.size(); i++) chk("rr_no_repeat", got_q[i] == got_q[i-1], 0);
        req_valid = '0; mem_cmd_ready = 1'b0; mem_rvalid = 1'b0;

        // Random traffic against the transaction model
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(199) == 0);
            req_valid = 3'($urandom_range(7));
            req_write = 3'($urandom_range(7));
            for (int i = 0; i < 3; i++) begin
                req_addr[i*32 +: 32]  = $urandom;
                req_len[i*10 +: 10]   = 10'($urandom_range(5));
                req_wdata[i*32 +: 32] = $urandom;
            end
            mem_cmd_ready = 1'($urandom_range(1));
            mem_wready    = 1'($urandom_range(1));
            mem_rvalid    = 1'($urandom_range(1));
            mem_rdata     = $urandom;
            model_cycle();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
